// File: rtl/rom_port_arbiter.sv
// Two-requester arbiter for the single-read-port instruction ROM.
// One ROM read at a time; ties are broken round-robin against the last owner.
module rom_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int ROM_LAT = 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_data,
  output logic              ic_valid,
  input  logic              dp_req,
  input  logic [ADDR_W-1:0] dp_addr,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_valid,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(ROM_LAT - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_rd_q, rom_rd_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] ic_data_q, ic_data_d;
  logic [DATA_W-1:0] dp_data_q, dp_data_d;
  logic              ic_valid_q, ic_valid_d;
  logic              dp_valid_q, dp_valid_d;
  logic              winner;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rom_addr_d   = rom_addr_q;
    ic_data_d    = ic_data_q;
    dp_data_d    = dp_data_q;
    rom_rd_d     = 1'b0;
    ic_valid_d   = 1'b0;
    dp_valid_d   = 1'b0;
    winner       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ic_req || dp_req) begin
          // On a tie the side that did not win last time goes first.
          winner     = (ic_req && dp_req) ? ~last_owner_q : dp_req;
          owner_d    = winner;
          rom_addr_d = winner ? dp_addr : ic_addr;
          rom_rd_d   = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          if (owner_q) begin
            dp_data_d  = rom_data;
            dp_valid_d = 1'b1;
          end else begin
            ic_data_d  = rom_data;
            ic_valid_d = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All FSM state and registered outputs; reset abandons any transaction.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rom_addr_q   <= '0;
      rom_rd_q     <= 1'b0;
      busy_q       <= 1'b0;
      ic_data_q    <= '0;
      dp_data_q    <= '0;
      ic_valid_q   <= 1'b0;
      dp_valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rom_addr_q   <= rom_addr_d;
      rom_rd_q     <= rom_rd_d;
      busy_q       <= busy_d;
      ic_data_q    <= ic_data_d;
      dp_data_q    <= dp_data_d;
      ic_valid_q   <= ic_valid_d;
      dp_valid_q   <= dp_valid_d;
    end
  end

  assign ic_data  = ic_data_q;
  assign dp_data  = dp_data_q;
  assign ic_valid = ic_valid_q;
  assign dp_valid = dp_valid_q;
  assign rom_addr = rom_addr_q;
  assign rom_rd   = rom_rd_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule
